// File: rtl/dutmem_ctrl.sv
// ---------------------------------------------------------------------------
// dutmem_ctrl
//
// Request front-end for the single-port synchronous memory dutmem2. Accepts
// in-order read/write requests on a valid/ready channel, drives the memory
// control pins from registers, captures the memory's registered read data
// two cycles after a read is accepted and hands it back through a small
// credit-checked response FIFO.
//
// Parameters:
//   DWIDTH    - data width (matches memory DWIDTH)
//   AWIDTH    - address width (matches memory AWIDTH)
//   RSP_DEPTH - response FIFO entries, power of two >= 2
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready      - request handshake
//   req_we/req_addr/req_wdata- request payload (wdata ignored for reads)
//   rsp_valid/rsp_ready      - response handshake
//   rsp_rdata                - response data (FIFO head, 0 when empty)
//   mem_ce/mem_we/mem_addr/mem_din - registered memory control pins
//   mem_dout                 - registered read data from the memory
//   wr_count/rd_count        - accepted write/read statistics
//
// Optional feature macro: DUTMEM_CTRL_STATS_EN
//   defined   - wr_count/rd_count are saturating 16-bit counters
//   undefined - both statistics outputs are tied to zero
// ---------------------------------------------------------------------------
module dutmem_ctrl #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 10,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  // Pointer width carries one extra wrap bit so full and empty differ.
  localparam int PW = $clog2(RSP_DEPTH) + 1;
  localparam int IW = PW - 1;

  logic              r_ce;
  logic              r_we;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_din;
  logic [1:0]        r_rdPipe;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [DWIDTH-1:0] r_fifo [RSP_DEPTH];

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [PW-1:0]     w_occ;
  logic [1:0]        w_inflight;
  logic [PW:0]       w_used;
  logic              w_credit;

  // Credit accounting: every read that has been accepted but not yet popped
  // owns one FIFO slot, whether it is still in the memory pipe or already
  // buffered. Only the registered state is used, so a pop in the same cycle
  // does not free a slot and rsp_ready never reaches req_ready.
  assign w_occ      = r_wptr - r_rptr;
  assign w_inflight = {1'b0, r_rdPipe[0]} + {1'b0, r_rdPipe[1]};
  assign w_used     = {1'b0, w_occ} + {{(PW-1){1'b0}}, w_inflight};
  assign w_credit   = (w_used < (PW+1)'(RSP_DEPTH));

  assign req_ready  = !rst && (req_we || w_credit);
  assign w_accept   = req_valid && req_ready;

  // FIFO status: full when the wrap bits differ and the index bits match.
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                      (r_wptr[IW-1:0] == r_rptr[IW-1:0]);
  assign w_push     = r_rdPipe[1];
  assign w_pop      = rsp_valid && rsp_ready;

  assign rsp_valid  = !w_empty;
  assign rsp_rdata  = w_empty ? '0 : r_fifo[r_rptr[IW-1:0]];

  assign mem_ce     = r_ce;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_din    = r_din;

  // Issue stage: the memory pins are registered copies of the accepted
  // request. Idle cycles drop ce/we but keep address and data stable so the
  // memory inputs do not toggle needlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce   <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else if (w_accept) begin
      r_ce   <= 1'b1;
      r_we   <= req_we;
      r_addr <= req_addr;
      r_din  <= req_wdata;
    end else begin
      r_ce   <= 1'b0;
      r_we   <= 1'b0;
    end
  end

  // Read tracking pipe: bit 0 marks a read driven onto the memory this
  // cycle, bit 1 marks that the memory has just registered its data, which
  // is therefore captured into the FIFO on the following edge. Reset drops
  // any reads still in the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdPipe <= 2'b00;
    end else begin
      r_rdPipe <= {r_rdPipe[0], w_accept && !req_we};
    end
  end

  // FIFO pointers. The credit rule keeps pushes away from a full FIFO; the
  // full gate only protects the stored data should that ever be violated.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push && !w_full) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  // FIFO storage needs no reset: an entry is only visible after it has been
  // written, and the empty case forces the output to zero.
  always_ff @(posedge clk) begin
    if (w_push && !w_full) begin
      r_fifo[r_wptr[IW-1:0]] <= mem_dout;
    end
  end

`ifdef DUTMEM_CTRL_STATS_EN
  logic [15:0] r_wrCount;
  logic [15:0] r_rdCount;

  // Statistics: count accepted writes and reads separately, saturating at
  // the top so a long run never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrCount <= '0;
      r_rdCount <= '0;
    end else if (w_accept) begin
      if (req_we && (r_wrCount != 16'hFFFF)) begin
        r_wrCount <= r_wrCount + 16'd1;
      end
      if (!req_we && (r_rdCount != 16'hFFFF)) begin
        r_rdCount <= r_rdCount + 16'd1;
      end
    end
  end

  assign wr_count = r_wrCount;
  assign rd_count = r_rdCount;
`else
  assign wr_count = 16'h0000;
  assign rd_count = 16'h0000;
`endif

endmodule
